// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART sensor command bridge.
//   op_t      : command opcode carried in command byte bits [7:6]
//   state_t   : command engine state encoding
//   DEF_*     : default reply codes (acknowledge, bad channel, empty channel)
//   bit_rev8  : mirrors a byte (bit 0 <-> bit 7) for hosts that send LSB-first
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'b00,
    OP_BURST  = 2'b01,
    OP_RST    = 2'b10,
    OP_STATUS = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SEND,
    S_FETCH,
    S_RST
  } state_t;

  localparam logic [7:0] DEF_ACK_CODE   = 8'hA5;
  localparam logic [7:0] DEF_NAK_CODE   = 8'h5A;
  localparam logic [7:0] DEF_EMPTY_CODE = 8'hEE;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) begin
      r[i] = b[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/heartbeat_led.sv
// Free-running heartbeat: o_led toggles once every HALF_PERIOD clocks.
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (LED off, counter reloaded)
//   o_led  : heartbeat output
module heartbeat_led #(
  parameter int unsigned HALF_PERIOD = 26000000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_led
);

  localparam int unsigned HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [HW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;

  // Count HALF_PERIOD-1 .. 0; the toggle happens on the zero cycle so each
  // LED level lasts exactly HALF_PERIOD clocks.
  always_comb begin
    cnt_d = cnt_q;
    led_d = led_q;
    if (cnt_q == '0) begin
      cnt_d = HW'(HALF_PERIOD - 1);
      led_d = ~led_q;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= HW'(HALF_PERIOD - 1);
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/uart_sensor_cmd_bridge.sv
// Command/response engine between the UART byte streams and NUM_CH sensor
// FIFO channels. Host commands: single read, burst drain, per-channel FSM
// reset and status query. Also owns the heartbeat LED.
//   i_rx_data/i_rx_valid/o_rx_ready : command bytes from the UART receiver
//   o_tx_data/o_tx_valid/i_tx_ready : reply bytes to the UART transmitter
//   i_ch_valid/i_ch_data            : per-channel FIFO heads (ch k at [8k+7:8k])
//   o_ch_extract                    : one-cycle FIFO pop strobe, one-hot or zero
//   o_ch_rst                        : per-channel I2C FSM reset pulse
//   o_busy                          : engine not idle
//   o_led_status                    : heartbeat
module uart_sensor_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned BURST_MAX       = 16,
  parameter int unsigned RST_CYCLES      = 4,
  parameter logic [7:0]  ACK_CODE        = DEF_ACK_CODE,
  parameter logic [7:0]  NAK_CODE        = DEF_NAK_CODE,
  parameter logic [7:0]  EMPTY_CODE      = DEF_EMPTY_CODE,
  parameter bit          RX_BIT_REVERSE  = 1'b1,
  parameter int unsigned LED_HALF_PERIOD = 26000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_valid,
  input  logic                  i_tx_ready,
  input  logic [NUM_CH-1:0]     i_ch_valid,
  input  logic [8*NUM_CH-1:0]   i_ch_data,
  output logic [NUM_CH-1:0]     o_ch_extract,
  output logic [NUM_CH-1:0]     o_ch_rst,
  output logic                  o_busy,
  output logic                  o_led_status
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  state_t              state_q, state_d;
  state_t              ret_q, ret_d;
  op_t                 op_q, op_d;
  logic [2:0]          ch_q, ch_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [RW-1:0]       rcnt_q, rcnt_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                rx_ready_q, rx_ready_d;
  logic                busy_q, busy_d;
  logic [NUM_CH-1:0]   extract_q, extract_d;
  logic [NUM_CH-1:0]   ch_rst_q, ch_rst_d;

  logic [7:0]          cmd_byte;
  logic                unused_cmd_bits;
  logic [7:0]          valid_pad;
  logic [63:0]         data_pad;
  logic [7:0]          head_data;
  logic                head_valid;
  logic                ch_bad;
  logic [NUM_CH-1:0]   ch_oh;

  assign cmd_byte        = RX_BIT_REVERSE ? bit_rev8(i_rx_data) : i_rx_data;
  // Command bits [5:3] are reserved and deliberately ignored.
  assign unused_cmd_bits = ^cmd_byte[5:3];

  // Pad the channel buses to the 3-bit channel field range so a latched
  // out-of-range channel can never index past the real vectors.
  assign valid_pad  = 8'(i_ch_valid);
  assign data_pad   = 64'(i_ch_data);
  assign head_data  = data_pad[{ch_q, 3'b000} +: 8];
  assign head_valid = valid_pad[ch_q];
  assign ch_bad     = ({5'b0, ch_q} >= 8'(NUM_CH));

  always_comb begin
    ch_oh = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_oh[k] = (ch_q == 3'(k));
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    op_d      = op_q;
    ch_d      = ch_q;
    cnt_d     = cnt_q;
    rcnt_d    = rcnt_q;
    tx_data_d = tx_data_q;
    ch_rst_d  = ch_rst_q;
    extract_d = '0;

    case (state_q)
      S_IDLE: begin
        if (rx_ready_q && i_rx_valid) begin
          op_d    = op_t'(cmd_byte[7:6]);
          ch_d    = cmd_byte[2:0];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (op_q != OP_STATUS && ch_bad) begin
          tx_data_d = NAK_CODE;
          ret_d     = S_IDLE;
          state_d   = S_SEND;
        end else begin
          case (op_q)
            OP_READ: begin
              if (head_valid) begin
                tx_data_d = head_data;
                extract_d = ch_oh;
              end else begin
                tx_data_d = EMPTY_CODE;
              end
              ret_d   = S_IDLE;
              state_d = S_SEND;
            end
            OP_BURST: begin
              tx_data_d = ACK_CODE;
              cnt_d     = '0;
              ret_d     = S_FETCH;
              state_d   = S_SEND;
            end
            OP_RST: begin
              rcnt_d   = RW'(RST_CYCLES);
              ch_rst_d = ch_oh;
              state_d  = S_RST;
            end
            OP_STATUS: begin
              tx_data_d = valid_pad;
              ret_d     = S_IDLE;
              state_d   = S_SEND;
            end
          endcase
        end
      end

      // tx_valid_q is high exactly while in S_SEND, so i_tx_ready alone
      // completes the handshake here.
      S_SEND: begin
        if (i_tx_ready) begin
          state_d = ret_q;
        end
      end

      S_FETCH: begin
        if (head_valid && (cnt_q < 8'(BURST_MAX))) begin
          tx_data_d = head_data;
          extract_d = ch_oh;
          cnt_d     = cnt_q + 8'd1;
          ret_d     = S_FETCH;
        end else begin
          tx_data_d = cnt_q;
          ret_d     = S_IDLE;
        end
        state_d = S_SEND;
      end

      // ch_rst was raised on entry; dropping it on the rcnt==1 cycle gives
      // a pulse of exactly RST_CYCLES clocks, and the ACK follows it.
      S_RST: begin
        if (rcnt_q == RW'(1)) begin
          ch_rst_d  = '0;
          tx_data_d = ACK_CODE;
          ret_d     = S_IDLE;
          state_d   = S_SEND;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    tx_valid_d = (state_d == S_SEND);
    rx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      op_q       <= OP_READ;
      ch_q       <= '0;
      cnt_q      <= '0;
      rcnt_q     <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      extract_q  <= '0;
      ch_rst_q   <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      op_q       <= op_d;
      ch_q       <= ch_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rx_ready_q <= rx_ready_d;
      busy_q     <= busy_d;
      extract_q  <= extract_d;
      ch_rst_q   <= ch_rst_d;
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_ch_extract = extract_q;
  assign o_ch_rst     = ch_rst_q;
  assign o_busy       = busy_q;

  heartbeat_led #(
    .HALF_PERIOD(LED_HALF_PERIOD)
  ) u_heartbeat (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_led (o_led_status)
  );

endmodule

// File: tb/tb_uart_sensor_cmd_bridge.sv
// Directed bench for uart_sensor_cmd_bridge: behavioural per-channel FIFOs,
// bit-reversed command bytes, hand-computed reply frames.
module tb_uart_sensor_cmd_bridge;

  localparam int unsigned NCH = 4;
  localparam int unsigned HP  = 20;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic [7:0]         i_rx_data;
  logic               i_rx_valid;
  logic               o_rx_ready;
  logic [7:0]         o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic [NCH-1:0]     i_ch_valid;
  logic [8*NCH-1:0]   i_ch_data;
  logic [NCH-1:0]     o_ch_extract;
  logic [NCH-1:0]     o_ch_rst;
  logic               o_busy;
  logic               o_led_status;

  uart_sensor_cmd_bridge #(
    .NUM_CH         (NCH),
    .BURST_MAX      (16),
    .RST_CYCLES     (4),
    .RX_BIT_REVERSE (1'b1),
    .LED_HALF_PERIOD(HP)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rx_data    (i_rx_data),
    .i_rx_valid   (i_rx_valid),
    .o_rx_ready   (o_rx_ready),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready),
    .i_ch_valid   (i_ch_valid),
    .i_ch_data    (i_ch_data),
    .o_ch_extract (o_ch_extract),
    .o_ch_rst     (o_ch_rst),
    .o_busy       (o_busy),
    .o_led_status (o_led_status)
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]     fifo [NCH][$];
  int             ext_cnt [NCH];
  int             rst_cnt [NCH];
  logic [NCH-1:0] pend_pop;
  logic [7:0]     got [$];

  function automatic logic [7:0] rev8(input logic [7:0] b);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  task automatic refresh_heads();
    for (int k = 0; k < NCH; k++) begin
      i_ch_valid[k]       = (fifo[k].size() > 0);
      i_ch_data[8*k +: 8] = (fifo[k].size() > 0) ? fifo[k][0] : 8'h00;
    end
  endtask

  task automatic clear_fifos();
    for (int k = 0; k < NCH; k++) begin
      fifo[k].delete();
      ext_cnt[k] = 0;
      rst_cnt[k] = 0;
    end
    refresh_heads();
  endtask

  // Monitor: count strobes mid-cycle; a pop requested this cycle takes
  // effect just after the following rising edge.
  always @(negedge i_clk) begin
    pend_pop = '0;
    for (int k = 0; k < NCH; k++) begin
      if (o_ch_rst[k] === 1'b1) rst_cnt[k]++;
      if (o_ch_extract[k] === 1'b1) begin
        ext_cnt[k]++;
        vectors++;
        if (i_ch_valid[k] !== 1'b1) begin
          miscompares++;
          $display("FAIL extract_on_empty ch%0d: valid=%b, required 1", k, i_ch_valid[k]);
        end else begin
          pend_pop[k] = 1'b1;
        end
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    for (int k = 0; k < NCH; k++) begin
      if (pend_pop[k] && fifo[k].size() > 0) fifo[k].delete(0);
    end
    refresh_heads();
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send_cmd(input logic [7:0] c);
    @(negedge i_clk);
    i_rx_data  = rev8(c);
    i_rx_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (o_rx_ready === 1'b1) begin
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        return;
      end
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL cmd_accept cmd=%h: o_rx_ready=%b, required 1", c, o_rx_ready);
  endtask

  task automatic get_byte(input bit stall, output logic [7:0] b, output bit ok);
    logic [7:0] held;
    bit         have;
    ok = 1'b0;
    b = 'x;
    have = 1'b0;
    held = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge i_clk);
      i_tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_tx_valid === 1'b1) begin
        if (have) begin
          vectors++;
          if (o_tx_data !== held) begin
            miscompares++;
            $display("FAIL tx_stable_while_stalled: data=%h, required %h", o_tx_data, held);
          end
        end
        if (i_tx_ready) begin
          b  = o_tx_data;
          ok = 1'b1;
          @(posedge i_clk);
          #1;
          i_tx_ready = 1'b0;
          return;
        end
        held = o_tx_data;
        have = 1'b1;
      end
    end
    i_tx_ready = 1'b0;
  endtask

  // Collects n reply bytes into got; a timed-out byte is recorded as X.
  task automatic recv_frame(input int n, input bit stall);
    logic [7:0] b;
    bit         ok;
    got.delete();
    for (int i = 0; i < n; i++) begin
      get_byte(stall, b, ok);
      got.push_back(ok ? b : 8'hxx);
    end
  endtask

  task automatic test_reset();
    i_rst      = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = '0;
    i_tx_ready = 1'b0;
    clear_fifos();
    repeat (3) @(negedge i_clk);
    vectors++;
    if ({o_rx_ready, o_tx_valid, o_tx_data, o_ch_extract, o_ch_rst, o_busy, o_led_status} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rx_rdy=%b tx_v=%b tx=%h ext=%b rst=%b busy=%b led=%b, required all 0",
               o_rx_ready, o_tx_valid, o_tx_data, o_ch_extract, o_ch_rst, o_busy, o_led_status);
    end
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    vectors++;
    if (o_rx_ready !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: rx_ready=%b busy=%b, required 1/0", o_rx_ready, o_busy);
    end
  endtask

  task automatic test_read_one();
    clear_fifos();
    fifo[2].push_back(8'h3C);
    refresh_heads();
    send_cmd(8'h02);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h3C) begin
      miscompares++;
      $display("FAIL read_one_data: got %h, required 3c", got[0]);
    end
    @(negedge i_clk);
    vectors++;
    if (ext_cnt[0] != 0 || ext_cnt[1] != 0 || ext_cnt[2] != 1 || ext_cnt[3] != 0) begin
      miscompares++;
      $display("FAIL read_one_extract: counts %0d,%0d,%0d,%0d, required 0,0,1,0",
               ext_cnt[0], ext_cnt[1], ext_cnt[2], ext_cnt[3]);
    end
    vectors++;
    if (o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL read_one_idle: busy=%b rx_ready=%b, required 0/1", o_busy, o_rx_ready);
    end
  endtask

  task automatic test_read_empty();
    clear_fifos();
    send_cmd(8'h01);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'hEE) begin
      miscompares++;
      $display("FAIL read_empty_code: got %h, required ee", got[0]);
    end
    vectors++;
    if (ext_cnt[0] + ext_cnt[1] + ext_cnt[2] + ext_cnt[3] != 0) begin
      miscompares++;
      $display("FAIL read_empty_extract: %0d pulses, required 0", ext_cnt[0] + ext_cnt[1] + ext_cnt[2] + ext_cnt[3]);
    end
  endtask

  task automatic test_burst_short();
    logic [7:0] exp [$];
    exp = '{8'hA5, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h05};
    clear_fifos();
    for (int i = 0; i < 5; i++) fifo[0].push_back(8'(8'h10 + i));
    refresh_heads();
    send_cmd(8'h40);
    recv_frame(7, 1'b0);
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL burst_short byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
    vectors++;
    if (ext_cnt[0] != 5) begin
      miscompares++;
      $display("FAIL burst_short_extracts: %0d, required 5", ext_cnt[0]);
    end
  endtask

  task automatic test_burst_empty();
    clear_fifos();
    send_cmd(8'h42);
    recv_frame(2, 1'b0);
    vectors++;
    if (got[0] !== 8'hA5 || got[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL burst_empty: got %h,%h, required a5,00", got[0], got[1]);
    end
  endtask

  task automatic test_burst_long_stall();
    logic [7:0] exp [$];
    clear_fifos();
    for (int i = 0; i < 20; i++) fifo[3].push_back(8'(8'h40 + i));
    refresh_heads();
    exp.push_back(8'hA5);
    for (int i = 0; i < 16; i++) exp.push_back(8'(8'h40 + i));
    exp.push_back(8'h10);
    send_cmd(8'h43);
    recv_frame(18, 1'b1);
    for (int i = 0; i < 18; i++) begin
      vectors++;
      if (got[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL burst_long byte%0d: got %h, required %h", i, got[i], exp[i]);
      end
    end
    repeat (2) @(negedge i_clk);
    vectors++;
    if (ext_cnt[3] != 16 || fifo[3].size() != 4) begin
      miscompares++;
      $display("FAIL burst_long_remaining: extracts %0d left %0d, required 16/4", ext_cnt[3], fifo[3].size());
    end
  endtask

  task automatic test_reset_ch();
    clear_fifos();
    send_cmd(8'h81);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'hA5) begin
      miscompares++;
      $display("FAIL reset_ch_ack: got %h, required a5", got[0]);
    end
    vectors++;
    if (rst_cnt[0] != 0 || rst_cnt[1] != 4 || rst_cnt[2] != 0 || rst_cnt[3] != 0) begin
      miscompares++;
      $display("FAIL reset_ch_pulse: cycles %0d,%0d,%0d,%0d, required 0,4,0,0",
               rst_cnt[0], rst_cnt[1], rst_cnt[2], rst_cnt[3]);
    end
    send_cmd(8'h06);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL bad_ch_read: got %h, required 5a", got[0]);
    end
    send_cmd(8'h86);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL bad_ch_reset: got %h, required 5a", got[0]);
    end
    vectors++;
    if (rst_cnt[0] + rst_cnt[2] + rst_cnt[3] != 0 || rst_cnt[1] != 4) begin
      miscompares++;
      $display("FAIL bad_ch_no_pulse: extra reset cycles seen");
    end
  endtask

  task automatic test_status();
    clear_fifos();
    fifo[1].push_back(8'h77);
    fifo[3].push_back(8'h88);
    refresh_heads();
    send_cmd(8'hC0);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h0A) begin
      miscompares++;
      $display("FAIL status: got %h, required 0a", got[0]);
    end
    send_cmd(8'hC5);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h0A) begin
      miscompares++;
      $display("FAIL status_ch_ignored: got %h, required 0a", got[0]);
    end
    vectors++;
    if (ext_cnt[1] + ext_cnt[3] != 0) begin
      miscompares++;
      $display("FAIL status_extract: %0d pulses, required 0", ext_cnt[1] + ext_cnt[3]);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_fifos();
    for (int i = 0; i < 10; i++) fifo[0].push_back(8'(8'h20 + i));
    refresh_heads();
    send_cmd(8'h40);
    recv_frame(3, 1'b0);
    vectors++;
    if (got[0] !== 8'hA5 || got[1] !== 8'h20 || got[2] !== 8'h21) begin
      miscompares++;
      $display("FAIL mid_burst_prefix: got %h,%h,%h, required a5,20,21", got[0], got[1], got[2]);
    end
    i_rst = 1'b1;
    #1;
    vectors++;
    if ({o_rx_ready, o_tx_valid, o_tx_data, o_ch_extract, o_ch_rst, o_busy, o_led_status} !== '0) begin
      miscompares++;
      $display("FAIL mid_burst_reset_outputs: tx_v=%b tx=%h ext=%b busy=%b, required all 0",
               o_tx_valid, o_tx_data, o_ch_extract, o_busy);
    end
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    vectors++;
    if (ext_cnt[0] != 2) begin
      miscompares++;
      $display("FAIL mid_burst_no_extract: %0d pulses, required 2", ext_cnt[0]);
    end
    send_cmd(8'h00);
    recv_frame(1, 1'b0);
    vectors++;
    if (got[0] !== 8'h22) begin
      miscompares++;
      $display("FAIL after_reset_read: got %h, required 22", got[0]);
    end
  endtask

  task automatic test_heartbeat();
    logic prev;
    int   cnt;
    bit   seen;
    @(negedge i_clk);
    prev = o_led_status;
    seen = 1'b0;
    for (int n = 0; n < 3 * HP && !seen; n++) begin
      @(negedge i_clk);
      if (o_led_status !== prev) seen = 1'b1;
    end
    prev = o_led_status;
    cnt  = 0;
    if (seen) begin
      for (int n = 0; n < 3 * HP; n++) begin
        @(negedge i_clk);
        cnt++;
        if (o_led_status !== prev) break;
      end
    end
    vectors++;
    if (cnt != HP) begin
      miscompares++;
      $display("FAIL heartbeat_period: %0d clocks, required %0d", cnt, HP);
    end
  endtask

  initial begin
    i_ch_valid = '0;
    i_ch_data  = '0;
    test_reset();
    test_read_one();
    test_read_empty();
    test_burst_short();
    test_burst_empty();
    test_burst_long_stall();
    test_reset_ch();
    test_status();
    test_reset_mid_burst();
    test_heartbeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
